// File: rtl/weight_stream_pkg.sv
// Shared types and default sizes for the weight stream server.
// Holds the four-state pass enum and the default weight width and memory
// depth used by the top module and the weight register file.
package weight_stream_pkg;

    localparam int DEF_DATA_WIDTH_FRAC = 8;
    localparam int DEF_NUM_INPUT       = 31;

    // Pass phases: IDLE before the first pass, STREAM while weights are
    // handed out, FINISH while finished is being raised, DONE after a pass.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } stream_state_e;

endpackage

// File: rtl/weight_stream_server_regfile.sv
// Weight storage for the weight stream server.
// Ports:
//   clk       rising-edge clock for the write port
//   wrEn_i    write strobe (already qualified by the caller)
//   wrAddr_i  write address
//   wrData_i  weight to store
//   rdAddr_i  asynchronous read address
//   rdData_o  weight at rdAddr_i, zero when the address is past the end
// Contents are never reset; a stream pass reads whatever was last loaded.
module weight_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 31,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic [DW-1:0] wrData_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic [DW-1:0] rdData_o
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [0:DEPTH-1];

    // Synchronous write port; out-of-range writes are filtered by the caller.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // The pointer can sit one past the last entry after a full-depth pass,
    // so guard the read to keep the output defined.
    assign rdData_o = ({1'b0, rdAddr_i} < DEPTH_W) ? mem[rdAddr_i] : '0;

endmodule

// File: rtl/weight_stream_server.sv
// Memory-side responder for the PIF neuron weight-fetch handshake.
// Streams up to NUM_INPUT stored weights, one per cycle in which the neuron
// raises readyMem, then raises finished to close the integration window.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   wrEn        weight write strobe (accepted only when not busy)
//   wrAddr      weight write address
//   wrData      signed weight to store
//   start       begin a stream pass (ignored while busy)
//   numWeights  weights requested for this pass, clipped to NUM_INPUT
//   readyMem    neuron request for the next weight
//   weightData  registered weight to the neuron, zero when none issued
//   finished    registered end-of-pass flag
//   busy        high while a pass is streaming or finishing
//   wrErr       one-cycle pulse when a write is dropped
module weight_stream_server
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH_FRAC = DEF_DATA_WIDTH_FRAC,
    parameter int NUM_INPUT       = DEF_NUM_INPUT,
    parameter int size_code       = $clog2(NUM_INPUT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrEn,
    input  logic [size_code-1:0]       wrAddr,
    input  logic [DATA_WIDTH_FRAC-1:0] wrData,
    input  logic                       start,
    input  logic [size_code:0]         numWeights,
    input  logic                       readyMem,
    output logic [DATA_WIDTH_FRAC-1:0] weightData,
    output logic                       finished,
    output logic                       busy,
    output logic                       wrErr
);

    localparam logic [size_code:0]   NUM_INPUT_W = (size_code + 1)'(NUM_INPUT);
    localparam logic [size_code:0]   CNT_ONE     = 1;
    localparam logic [size_code-1:0] PTR_ONE     = 1;

    stream_state_e              state_q;
    logic [size_code-1:0]       ptr_q;
    logic [size_code:0]         cnt_q;
    logic [DATA_WIDTH_FRAC-1:0] weightData_q;
    logic                       finished_q;
    logic                       busy_q;
    logic                       wrErr_q;

    logic                       canWrite_d;
    logic                       wrInRange_d;
    logic                       wrCommit_d;
    logic                       wrReject_d;
    logic [size_code:0]         startCnt_d;
    logic                       lastIssue_d;
    logic [DATA_WIDTH_FRAC-1:0] rdData_d;

    // Writes land only between passes so the stream never sees a weight
    // change underneath it.
    assign canWrite_d  = (state_q == IDLE) || (state_q == DONE);
    assign wrInRange_d = ({1'b0, wrAddr} < NUM_INPUT_W);
    assign wrCommit_d  = wrEn && canWrite_d && wrInRange_d;
    assign wrReject_d  = wrEn && !(canWrite_d && wrInRange_d);

    assign startCnt_d  = (numWeights > NUM_INPUT_W) ? NUM_INPUT_W : numWeights;
    assign lastIssue_d = ({1'b0, ptr_q} == (cnt_q - CNT_ONE));

    weight_regfile #(
        .DW    (DATA_WIDTH_FRAC),
        .DEPTH (NUM_INPUT),
        .AW    (size_code)
    ) u_regfile (
        .clk      (clk),
        .wrEn_i   (wrCommit_d),
        .wrAddr_i (wrAddr),
        .wrData_i (wrData),
        .rdAddr_i (ptr_q),
        .rdData_o (rdData_d)
    );

    // Pass sequencing, pointer/count tracking and all registered outputs.
    // finished is raised from FINISH, one edge after the last weight, so the
    // last weight and finished never share a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            weightData_q <= '0;
            finished_q   <= 1'b0;
            busy_q       <= 1'b0;
            wrErr_q      <= 1'b0;
        end else begin
            wrErr_q <= wrReject_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ptr_q      <= '0;
                        cnt_q      <= startCnt_d;
                        finished_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= (startCnt_d == '0) ? FINISH : STREAM;
                    end
                end
                STREAM: begin
                    if (readyMem) begin
                        weightData_q <= rdData_d;
                        ptr_q        <= ptr_q + PTR_ONE;
                        if (lastIssue_d) begin
                            state_q <= FINISH;
                        end
                    end else begin
                        weightData_q <= '0;
                    end
                end
                FINISH: begin
                    weightData_q <= '0;
                    finished_q   <= 1'b1;
                    if (!start) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign weightData = weightData_q;
    assign finished   = finished_q;
    assign busy       = busy_q;
    assign wrErr      = wrErr_q;

endmodule

// File: tb/tb_weight_stream_server.sv
// Self-checking bench for weight_stream_server. A queue-based model of a
// stream pass predicts every output each cycle; directed scenarios are
// followed by a randomized phase.
module tb_weight_stream_server;

    logic              clk;
    logic              reset;
    logic              wrEn;
    logic [4:0]        wrAddr;
    logic [7:0]        wrData;
    logic              start;
    logic [5:0]        numWeights;
    logic              readyMem;
    logic signed [7:0] weightData;
    logic              finished;
    logic              busy;
    logic              wrErr;

    int errors = 0;
    int checks = 0;

    logic [7:0]        refMem [0:30];
    logic [7:0]        pending [$];
    logic signed [7:0] expWeight;
    logic              expFinished;
    logic              expBusy;
    logic              expWrErr;

    weight_stream_server dut (
        .clk        (clk),
        .reset      (reset),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .start      (start),
        .numWeights (numWeights),
        .readyMem   (readyMem),
        .weightData (weightData),
        .finished   (finished),
        .busy       (busy),
        .wrErr      (wrErr)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every DUT input for the coming edge.
    task automatic applyStimulus(input logic s, input int nw, input logic rdy,
                                 input logic we, input int wa, input int wd);
        start      = s;
        numWeights = 6'(nw);
        readyMem   = rdy;
        wrEn       = we;
        wrAddr     = 5'(wa);
        wrData     = 8'(wd);
    endtask

    // Predict what the coming edge does: a pass is a queue of the first
    // min(numWeights,31) stored weights, popped on each ready cycle; once the
    // queue is empty the pass reports finished and ends when start is low.
    task automatic modelEdge();
        bit rejected;
        int n;
        rejected = wrEn && (expBusy || int'(wrAddr) >= 31);
        expWrErr = rejected;
        if (wrEn && !rejected) refMem[wrAddr] = wrData;
        if (!expBusy) begin
            if (start) begin
                n = (int'(numWeights) > 31) ? 31 : int'(numWeights);
                pending.delete();
                for (int i = 0; i < n; i++) pending.push_back(refMem[i]);
                expBusy     = 1'b1;
                expFinished = 1'b0;
            end
        end else if (pending.size() != 0) begin
            expWeight = readyMem ? signed'(pending.pop_front()) : 8'sd0;
        end else begin
            expWeight   = 8'sd0;
            expFinished = 1'b1;
            if (!start) expBusy = 1'b0;
        end
    endtask

    task automatic modelReset();
        pending.delete();
        expWeight   = 8'sd0;
        expFinished = 1'b0;
        expBusy     = 1'b0;
        expWrErr    = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (weightData === expWeight) else begin
            errors++;
            $error("[TB] FAIL %s weightData observed=%0d expected=%0d", tag, weightData, expWeight);
        end
        checks++;
        assert (finished === expFinished) else begin
            errors++;
            $error("[TB] FAIL %s finished observed=%b expected=%b", tag, finished, expFinished);
        end
        checks++;
        assert (busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
        end
        checks++;
        assert (wrErr === expWrErr) else begin
            errors++;
            $error("[TB] FAIL %s wrErr observed=%b expected=%b", tag, wrErr, expWrErr);
        end
    endtask

    // One clock: predict, take the edge, compare just after it.
    task automatic cycle(input string tag);
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any edge.
    task automatic applyReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
        reset = 1'b1;
    endtask

    task automatic runIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0);
            cycle(tag);
        end
    endtask

    initial begin
        int pattern [7] = '{1, 0, 0, 1, 1, 0, 1};
        int loadVals [4] = '{8'h10, 8'hF0, 8'h7F, 8'h80};

        reset = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 0, 0);
        modelReset();
        for (int i = 0; i < 31; i++) refMem[i] = 8'h00;
        #1;
        checkOutput("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] loading weight memory");
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b1, i, (i < 4) ? loadVals[i] : int'($urandom_range(0, 255)));
            cycle("load");
        end

        $display("[TB] four weights, readyMem held high");
        applyStimulus(1'b1, 4, 1'b1, 1'b0, 0, 0);
        cycle("s4_start");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, 0);
            cycle("s4_stream");
        end

        $display("[TB] four weights, readyMem gaps");
        applyStimulus(1'b1, 4, 1'b0, 1'b0, 0, 0);
        cycle("gap_start");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 4, 1'(pattern[i]), 1'b0, 0, 0);
            cycle("gap_stream");
        end
        runIdle(3, "gap_tail");

        $display("[TB] zero-length pass, start held two extra cycles");
        applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, 0);
        cycle("zero_start");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, 0);
            cycle("zero_hold");
        end
        runIdle(2, "zero_tail");

        $display("[TB] oversized pass clipped to full depth");
        applyStimulus(1'b1, 40, 1'b0, 1'b0, 0, 0);
        cycle("big_start");
        for (int i = 0; i < 300 && expBusy; i++) begin
            applyStimulus(1'b0, 40, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
            cycle("big_stream");
        end
        runIdle(2, "big_tail");

        $display("[TB] rejected writes");
        applyStimulus(1'b1, 4, 1'b0, 1'b0, 0, 0);
        cycle("rej_start");
        applyStimulus(1'b0, 4, 1'b0, 1'b1, 1, 8'h55);
        cycle("rej_busy_write");
        applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("rej_drain");
        applyStimulus(1'b0, 4, 1'b0, 1'b1, 31, 8'h33);
        cycle("rej_range_write");
        applyStimulus(1'b1, 4, 1'b1, 1'b0, 0, 0);
        cycle("rej_readback_start");
        applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("rej_readback");

        $display("[TB] write and start on the same edge");
        applyStimulus(1'b1, 1, 1'b1, 1'b1, 0, 8'hA5);
        cycle("wrstart_start");
        applyStimulus(1'b0, 1, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("wrstart_stream");

        $display("[TB] reset during a pass");
        applyStimulus(1'b1, 4, 1'b1, 1'b0, 0, 0);
        cycle("rst_start");
        applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, 0);
        cycle("rst_w0");
        cycle("rst_w1");
        applyReset("rst_mid");
        runIdle(1, "rst_idle");
        applyStimulus(1'b1, 4, 1'b1, 1'b0, 0, 0);
        cycle("rst_restart");
        applyStimulus(1'b0, 4, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("rst_restream");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 40)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
